// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding, width defaults and requester indices for mem_port_arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;

   localparam logic REQ_IF  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/Mux2way16.sv
// Two-way word multiplexer shared by the address and write-data steering paths.
module Mux2way16 #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] out
);

   assign out = sel ? b : a;

endmodule

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that did not win last time gets the port.
module arb_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid = req0 | req1;
      if (req0 && req1)
         winner = ~last;
      else if (req1)
         winner = REQ_MEM;
      else
         winner = REQ_IF;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Define ARB_TIMEOUT_EN to abort a stalled access after TIMEOUT busy cycles with err set.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              we0,
   input  logic              we1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_sel,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t state, state_nxt;
   logic owner, owner_nxt;
   logic last, last_nxt;
   logic gnt0_nxt, gnt1_nxt, ack0_nxt, ack1_nxt, err_nxt;
   logic mem_sel_nxt, mem_req_nxt, mem_we_nxt;
   logic [DATA_W-1:0] rdata_nxt, mem_wdata_nxt, wdata_mux;
   logic [ADDR_W-1:0] mem_addr_nxt, addr_mux;
   logic pick_valid, pick_winner, we_mux;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

   arb_rr_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (last),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // Muxes steer on the prospective owner so the latch happens on the granting edge.
   Mux2way16 #(.W(ADDR_W)) u_addr_mux (
      .a   (addr0),
      .b   (addr1),
      .sel (pick_winner),
      .out (addr_mux)
   );

   Mux2way16 #(.W(DATA_W)) u_wdata_mux (
      .a   (wdata0),
      .b   (wdata1),
      .sel (pick_winner),
      .out (wdata_mux)
   );

   assign we_mux = pick_winner ? we1 : we0;

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      last_nxt      = last;
      gnt0_nxt      = gnt0;
      gnt1_nxt      = gnt1;
      ack0_nxt      = 1'b0;
      ack1_nxt      = 1'b0;
      err_nxt       = 1'b0;
      rdata_nxt     = rdata;
      mem_sel_nxt   = mem_sel;
      mem_req_nxt   = 1'b0;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      mem_we_nxt    = mem_we;
`ifdef ARB_TIMEOUT_EN
      cnt_nxt       = cnt;
`endif
      case (state)
         IDLE: begin
            gnt0_nxt = 1'b0;
            gnt1_nxt = 1'b0;
            if (pick_valid) begin
               state_nxt     = BUSY;
               owner_nxt     = pick_winner;
               mem_sel_nxt   = pick_winner;
               mem_req_nxt   = 1'b1;
               mem_addr_nxt  = addr_mux;
               mem_wdata_nxt = wdata_mux;
               mem_we_nxt    = we_mux;
               gnt0_nxt      = (pick_winner == REQ_IF);
               gnt1_nxt      = (pick_winner == REQ_MEM);
`ifdef ARB_TIMEOUT_EN
               cnt_nxt       = '0;
`endif
            end
         end
         BUSY: begin
            mem_req_nxt = 1'b1;
            if (mem_ready) begin
               state_nxt   = DONE;
               mem_req_nxt = 1'b0;
               ack0_nxt    = (owner == REQ_IF);
               ack1_nxt    = (owner == REQ_MEM);
               if (!mem_we)
                  rdata_nxt = mem_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt + 1'b1 == CNT_W'(TIMEOUT)) begin
               state_nxt   = DONE;
               mem_req_nxt = 1'b0;
               ack0_nxt    = (owner == REQ_IF);
               ack1_nxt    = (owner == REQ_MEM);
               err_nxt     = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
`endif
         end
         DONE: begin
            state_nxt = IDLE;
            gnt0_nxt  = 1'b0;
            gnt1_nxt  = 1'b0;
            last_nxt  = owner;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Every output is a flop; reset abandons any access in flight without an ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= REQ_IF;
         last      <= REQ_MEM;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         mem_sel   <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         gnt0      <= gnt0_nxt;
         gnt1      <= gnt1_nxt;
         ack0      <= ack0_nxt;
         ack1      <= ack1_nxt;
         err       <= err_nxt;
         rdata     <= rdata_nxt;
         mem_sel   <= mem_sel_nxt;
         mem_req   <= mem_req_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         mem_we    <= mem_we_nxt;
`ifdef ARB_TIMEOUT_EN
         cnt       <= cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle,
// plus directed literal checks. Covers both builds of ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 15;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ready = 0;
   logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
   logic gnt0, gnt1, ack0, ack1, err, mem_sel, mem_req, mem_we;
   logic [15:0] rdata, mem_addr, mem_wdata;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
      .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
      .rdata(rdata), .err(err), .mem_sel(mem_sel), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic r1,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic w0, input logic w1,
                                input logic rdy, input logic [15:0] mrd);
      req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
      wdata0 = d0; wdata1 = d1; we0 = w0; we1 = w1;
      mem_ready = rdy; mem_rdata = mrd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: who holds the port, how long it has waited, and what it reported.
   bit model_on = 1'b0;
   int m_phase;                 // 0 waiting for a request, 1 access in flight, 2 reporting completion
   int m_owner, m_last, m_wait;
   logic e_gnt[2], e_ack[2];
   logic e_err, e_sel, e_req, e_we;
   logic [15:0] e_rdata, e_addr, e_wdata;

   task automatic modelFinish(input logic aborted);
      e_req = 1'b0;
      e_ack[m_owner] = 1'b1;
      e_err = aborted;
      if (!aborted && !e_we) e_rdata = mem_rdata;
      m_phase = 2;
   endtask

   always @(posedge clk) begin
      logic [15:0] a_in[2];
      logic [15:0] d_in[2];
      logic w_in[2];
      a_in[0] = addr0; a_in[1] = addr1;
      d_in[0] = wdata0; d_in[1] = wdata1;
      w_in[0] = we0; w_in[1] = we1;
      if (!rst_n) begin
         model_on = 1'b1;
         m_phase = 0; m_owner = 0; m_last = 1; m_wait = 0;
         e_gnt[0] = 0; e_gnt[1] = 0; e_ack[0] = 0; e_ack[1] = 0;
         e_err = 0; e_sel = 0; e_req = 0; e_we = 0;
         e_rdata = 0; e_addr = 0; e_wdata = 0;
      end else if (m_phase == 2) begin
         e_ack[0] = 0; e_ack[1] = 0; e_err = 0;
         e_gnt[0] = 0; e_gnt[1] = 0;
         m_last = m_owner;
         m_phase = 0;
      end else if (m_phase == 1) begin
         if (mem_ready) modelFinish(1'b0);
         else begin
            m_wait++;
            if (TO_EN && m_wait == TIMEOUT) modelFinish(1'b1);
         end
      end else if (req0 || req1) begin
         m_owner = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
         e_gnt[m_owner] = 1'b1;
         e_sel = m_owner[0];
         e_addr = a_in[m_owner];
         e_wdata = d_in[m_owner];
         e_we = w_in[m_owner];
         e_req = 1'b1;
         m_wait = 0;
         m_phase = 1;
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         checkOutput("gnt0", gnt0, e_gnt[0]);
         checkOutput("gnt1", gnt1, e_gnt[1]);
         checkOutput("ack0", ack0, e_ack[0]);
         checkOutput("ack1", ack1, e_ack[1]);
         checkOutput("err", err, e_err);
         checkOutput("rdata", rdata, e_rdata);
         checkOutput("mem_sel", mem_sel, e_sel);
         checkOutput("mem_req", mem_req, e_req);
         checkOutput("mem_addr", mem_addr, e_addr);
         checkOutput("mem_wdata", mem_wdata, e_wdata);
         checkOutput("mem_we", mem_we, e_we);
         checkOutput("gnt_exclusive", gnt0 & gnt1, 0);
         checkOutput("ack_exclusive", ack0 & ack1, 0);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      // Reset and lone read
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      checkOutput("rst_outputs", {gnt0, gnt1, ack0, ack1, err, mem_sel, mem_req, mem_we}, 0);
      checkOutput("rst_words", {rdata, mem_addr}, 0);
      rst_n = 1'b1;
      applyStimulus(1, 0, 16'h0040, 0, 0, 0, 0, 0, 1, 16'hBEEF);
      tick();
      checkOutput("t1_mem_req", mem_req, 1);
      checkOutput("t1_mem_addr", mem_addr, 16'h0040);
      checkOutput("t1_mem_sel", mem_sel, 0);
      checkOutput("t1_gnt", {gnt0, gnt1}, 2'b10);
      tick();
      checkOutput("t1_ack0", {ack0, ack1}, 2'b10);
      checkOutput("t1_rdata", rdata, 16'hBEEF);
      req0 = 0;
      tick();
      checkOutput("t1_idle", {gnt0, ack0, mem_req}, 0);

      // Tie fairness: last winner was requester 0, so requester 1 leads
      applyStimulus(1, 1, 16'h0100, 16'h0200, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         mem_rdata = 16'hA000 + 16'(i);
         tick();
         checkOutput("t2_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput("t2_addr", mem_addr, (i % 2 == 0) ? 16'h0200 : 16'h0100);
         tick();
         checkOutput("t2_ack", {ack0, ack1}, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i == 3) begin req0 = 0; req1 = 0; end
         tick();
      end
      checkOutput("t2_rdata", rdata, 16'hA003);

      // Write with a five-cycle stall
      applyStimulus(0, 1, 0, 16'h1234, 0, 16'h00FF, 0, 1, 0, 16'hDEAD);
      tick();
      for (int k = 1; k <= 6; k++) begin
         checkOutput("t3_busy", {mem_req, mem_we, gnt1}, 3'b111);
         checkOutput("t3_hold", {mem_addr, mem_wdata}, {16'h1234, 16'h00FF});
         if (k == 6) mem_ready = 1;
         tick();
      end
      checkOutput("t3_ack1", {ack1, mem_req}, 2'b10);
      checkOutput("t3_rdata_kept", rdata, 16'hA003);
      req1 = 0; mem_ready = 0;
      tick();

      // Owner inputs change after grant
      applyStimulus(1, 0, 16'h0ABC, 0, 0, 0, 0, 0, 0, 0);
      tick();
      addr0 = 16'hFFFF;
      checkOutput("t4_latched", mem_addr, 16'h0ABC);
      tick();
      checkOutput("t4_busy_addr", mem_addr, 16'h0ABC);
      mem_ready = 1; mem_rdata = 16'h1357;
      tick();
      checkOutput("t4_done_addr", mem_addr, 16'h0ABC);
      checkOutput("t4_rdata", rdata, 16'h1357);
      req0 = 0;
      tick();

      // Reset mid-access, then tie after release
      applyStimulus(1, 0, 16'h0555, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      rst_n = 0;
      tick();
      checkOutput("t5_rst_outputs", {gnt0, gnt1, ack0, ack1, err, mem_req, mem_sel}, 0);
      checkOutput("t5_rst_words", {rdata, mem_addr, mem_wdata}, 0);
      rst_n = 1;
      applyStimulus(1, 1, 16'h0011, 16'h0022, 0, 0, 0, 0, 1, 16'h2468);
      tick();
      checkOutput("t5_tie_gnt", {gnt0, gnt1}, 2'b10);
      tick();
      checkOutput("t5_ack0", {ack0, ack1}, 2'b10);
      req0 = 0; req1 = 0;
      tick();

      // Memory never answers
      applyStimulus(1, 0, 16'h0777, 0, 0, 0, 0, 0, 0, 16'h9999);
      tick();
      if (TO_EN) begin
         n = 1;
         while (!ack0 && n < 40) begin
            tick();
            n++;
         end
         checkOutput("t6_timeout_cycle", n, TIMEOUT + 1);
         checkOutput("t6_ack_err", {ack0, err}, 2'b11);
         checkOutput("t6_rdata_kept", rdata, 16'h2468);
         req0 = 0;
         tick();
         tick();
         checkOutput("t6_err_cleared", err, 0);
      end else begin
         for (int k = 0; k < 30; k++) tick();
         checkOutput("t6_still_busy", {mem_req, gnt0, err}, 3'b110);
         checkOutput("t6_rdata_kept", rdata, 16'h2468);
         req0 = 0;
         rst_n = 0;
         tick();
         rst_n = 1;
         tick();
      end

      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
